cmac_core_wt_shadow: RTL and testbench

//  Sits directly downstream of the CMAC input retiming stage, upstream of the MAC cells.

---
 rtl/cmac_core_pkg.sv | 9 +
 rtl/cmac_wt_cell_buf.sv | 50 +++++
 rtl/cmac_core_wt_shadow.sv | 77 +++++++
 tb/tb_cmac_core_wt_shadow.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_core_pkg.sv
// Shared constants for the CMAC core slice: atom geometry and stripe_info pd layout.
package cmac_core_pkg;
  localparam int CMAC_ATOMC      = 8;
  localparam int CMAC_ATOMK_HALF = 4;
  localparam int CMAC_BPE        = 8;
  localparam int PD_W            = 9;
  localparam int ST_BIT          = 5;
  localparam int END_BIT         = 6;
endpackage

// File: rtl/cmac_wt_cell_buf.sv
// One MAC cell's weight buffer: a shadow bank filled by weight beats and an
// active bank refreshed from it at stripe start.
module cmac_wt_cell_buf
  import cmac_core_pkg::*;
#(
  parameter int ATOMC = CMAC_ATOMC,
  parameter int BPE   = CMAC_BPE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic                 promote_en,
  input  logic [ATOMC-1:0]     wt_mask,
  input  logic [ATOMC*BPE-1:0] wt_data,
  output logic [ATOMC-1:0]     actv_mask,
  output logic [ATOMC*BPE-1:0] actv_data,
  output logic                 shadow_vld,
  output logic                 ovr
);
  logic [ATOMC-1:0]     shadow_mask;
  logic [ATOMC*BPE-1:0] shadow_data;
  logic                 promote;

  // A stripe start only moves weights that were actually loaded; otherwise the
  // active bank is reused as-is.
  assign promote = promote_en & shadow_vld;
  assign ovr     = load_en & shadow_vld & ~promote;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mask <= '0;
      actv_mask   <= '0;
      shadow_vld  <= 1'b0;
    end else begin
      if (load_en) shadow_mask <= wt_mask;
      if (promote) actv_mask   <= shadow_mask;
      // A load in the promote cycle belongs to the next stripe, so it keeps vld set.
      if (load_en)      shadow_vld <= 1'b1;
      else if (promote) shadow_vld <= 1'b0;
    end
  end

  // Byte storage is qualified by the masks and carries no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ATOMC; k++) begin
      if (load_en && wt_mask[k])     shadow_data[k*BPE +: BPE] <= wt_data[k*BPE +: BPE];
      if (promote && shadow_mask[k]) actv_data[k*BPE +: BPE]   <= shadow_data[k*BPE +: BPE];
    end
  end
endmodule

// File: rtl/cmac_core_wt_shadow.sv
// CMAC weight shadow stage: double-buffers per-cell weights and re-registers the
// data beat so it leaves together with the active weights it consumes.
module cmac_core_wt_shadow
  import cmac_core_pkg::*;
#(
  parameter int ATOMC      = CMAC_ATOMC,
  parameter int ATOMK_HALF = CMAC_ATOMK_HALF,
  parameter int BPE        = CMAC_BPE
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rstn,
  input  logic                            in_dat_pvld,
  input  logic [ATOMC-1:0]                in_dat_mask,
  input  logic [PD_W-1:0]                 in_dat_pd,
  input  logic [ATOMC*BPE-1:0]            in_dat_data,
  input  logic                            in_wt_pvld,
  input  logic [ATOMC-1:0]                in_wt_mask,
  input  logic [ATOMK_HALF-1:0]           in_wt_sel,
  input  logic [ATOMC*BPE-1:0]            in_wt_data,
  output logic                            dat_pvld,
  output logic [ATOMC-1:0]                dat_mask,
  output logic [PD_W-1:0]                 dat_pd,
  output logic [ATOMC*BPE-1:0]            dat_data,
  output logic [ATOMK_HALF*ATOMC-1:0]     wt_actv_mask,
  output logic [ATOMK_HALF*ATOMC*BPE-1:0] wt_actv_data,
  output logic [ATOMK_HALF-1:0]           wt_shadow_vld,
  output logic                            wt_ovr
);
  logic                                     stripe_st;
  logic [ATOMK_HALF-1:0]                    load_en;
  logic [ATOMK_HALF-1:0]                    cell_ovr;
  logic [ATOMK_HALF-1:0][ATOMC-1:0]         cell_mask;
  logic [ATOMK_HALF-1:0][ATOMC*BPE-1:0]     cell_data;

  assign stripe_st = in_dat_pvld & in_dat_pd[ST_BIT];
  assign load_en   = {ATOMK_HALF{in_wt_pvld}} & in_wt_sel;

  for (genvar c = 0; c < ATOMK_HALF; c++) begin : g_cell
    cmac_wt_cell_buf #(.ATOMC(ATOMC), .BPE(BPE)) u_cell (
      .clk        (nvdla_core_clk),
      .rst_n      (nvdla_core_rstn),
      .load_en    (load_en[c]),
      .promote_en (stripe_st),
      .wt_mask    (in_wt_mask),
      .wt_data    (in_wt_data),
      .actv_mask  (cell_mask[c]),
      .actv_data  (cell_data[c]),
      .shadow_vld (wt_shadow_vld[c]),
      .ovr        (cell_ovr[c])
    );
  end

  assign wt_actv_mask = cell_mask;
  assign wt_actv_data = cell_data;

  // Mask/pd keep updating one cycle past the last beat so they drop to zero with pvld.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dat_pvld <= 1'b0;
      dat_mask <= '0;
      dat_pd   <= '0;
      wt_ovr   <= 1'b0;
    end else begin
      dat_pvld <= in_dat_pvld;
      if (in_dat_pvld || dat_pvld) begin
        dat_mask <= in_dat_mask;
        dat_pd   <= in_dat_pd;
      end
      wt_ovr <= |cell_ovr;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    for (int k = 0; k < ATOMC; k++)
      if (in_dat_pvld && in_dat_mask[k]) dat_data[k*BPE +: BPE] <= in_dat_data[k*BPE +: BPE];
  end
endmodule

// File: tb/tb_cmac_core_wt_shadow.sv
// Directed bench for cmac_core_wt_shadow with an in-order expectation scoreboard.
module tb_cmac_core_wt_shadow;
  logic         clk = 1'b0;
  logic         rstn;
  logic         in_dat_pvld;
  logic [7:0]   in_dat_mask;
  logic [8:0]   in_dat_pd;
  logic [63:0]  in_dat_data;
  logic         in_wt_pvld;
  logic [7:0]   in_wt_mask;
  logic [3:0]   in_wt_sel;
  logic [63:0]  in_wt_data;
  logic         dat_pvld;
  logic [7:0]   dat_mask;
  logic [8:0]   dat_pd;
  logic [63:0]  dat_data;
  logic [31:0]  wt_actv_mask;
  logic [255:0] wt_actv_data;
  logic [3:0]   wt_shadow_vld;
  logic         wt_ovr;

  int n_cmp = 0;
  int n_bad = 0;
  string        tag_q[$];
  logic [255:0] val_q[$];

  localparam logic [8:0] PD_ST  = 9'h020;
  localparam logic [8:0] PD_END = 9'h040;

  always #5 clk = ~clk;

  cmac_core_wt_shadow dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_dat_pvld     (in_dat_pvld),
    .in_dat_mask     (in_dat_mask),
    .in_dat_pd       (in_dat_pd),
    .in_dat_data     (in_dat_data),
    .in_wt_pvld      (in_wt_pvld),
    .in_wt_mask      (in_wt_mask),
    .in_wt_sel       (in_wt_sel),
    .in_wt_data      (in_wt_data),
    .dat_pvld        (dat_pvld),
    .dat_mask        (dat_mask),
    .dat_pd          (dat_pd),
    .dat_data        (dat_data),
    .wt_actv_mask    (wt_actv_mask),
    .wt_actv_data    (wt_actv_data),
    .wt_shadow_vld   (wt_shadow_vld),
    .wt_ovr          (wt_ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [255:0] v);
    tag_q.push_back(t);
    val_q.push_back(v);
  endtask

  task automatic cmp(input logic [255:0] obs);
    string t;
    logic [255:0] e;
    n_cmp++;
    if (val_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_underflow obs=%0h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = val_q.pop_front();
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", t, obs, e);
    end
  endtask

  task automatic idle();
    in_dat_pvld = 1'b0; in_dat_mask = '0; in_dat_pd = '0; in_dat_data = '0;
    in_wt_pvld  = 1'b0; in_wt_mask  = '0; in_wt_sel = '0; in_wt_data  = '0;
  endtask

  task automatic wt(input int c, input logic [7:0] m, input logic [63:0] d);
    in_wt_pvld = 1'b1; in_wt_mask = m; in_wt_data = d;
    in_wt_sel  = 4'b0001 << c;
  endtask

  task automatic dat(input logic [8:0] pd, input logic [7:0] m, input logic [63:0] d);
    in_dat_pvld = 1'b1; in_dat_pd = pd; in_dat_mask = m; in_dat_data = d;
  endtask

  initial begin
    // Reset with junk on the inputs
    rstn = 1'b0;
    in_dat_pvld = 1'b1; in_dat_mask = 8'($urandom); in_dat_pd = 9'($urandom);
    in_dat_data = {$urandom, $urandom};
    in_wt_pvld = 1'b1; in_wt_mask = 8'($urandom); in_wt_sel = 4'b0010;
    in_wt_data = {$urandom, $urandom};
    push("rst_dat_pvld", 256'(1'b0));
    push("rst_actv_mask", 256'(32'h0));
    push("rst_shadow_vld", 256'(4'h0));
    push("rst_ovr", 256'(1'b0));
    push("rst_dat_mask", 256'(8'h0));
    tick(); tick();
    cmp(256'(dat_pvld)); cmp(256'(wt_actv_mask)); cmp(256'(wt_shadow_vld));
    cmp(256'(wt_ovr)); cmp(256'(dat_mask));
    idle();
    rstn = 1'b1;
    tick();

    // Load cell0 with 01..08, promote two cycles later
    wt(0, 8'hFF, 64'h0807060504030201);
    push("t1_shadow_vld", 256'(4'b0001));
    tick();
    cmp(256'(wt_shadow_vld));
    idle();
    tick();
    dat(PD_ST, 8'hFF, 64'h1122334455667788);
    push("t1_actv_mask0", 256'(8'hFF));
    push("t1_actv_data0", 256'(64'h0807060504030201));
    push("t1_shadow_vld_clr", 256'(4'b0000));
    push("t1_dat_pvld", 256'(1'b1));
    push("t1_dat_pd", 256'(PD_ST));
    push("t1_dat_data", 256'(64'h1122334455667788));
    tick();
    cmp(256'(wt_actv_mask[7:0])); cmp(256'(wt_actv_data[63:0])); cmp(256'(wt_shadow_vld));
    cmp(256'(dat_pvld)); cmp(256'(dat_pd)); cmp(256'(dat_data));

    // Trailing cycle clears mask/pd but data bytes hold
    idle();
    push("tail_dat_pvld", 256'(1'b0));
    push("tail_dat_mask", 256'(8'h00));
    push("tail_dat_pd", 256'(9'h0));
    push("tail_dat_data", 256'(64'h1122334455667788));
    tick();
    cmp(256'(dat_pvld)); cmp(256'(dat_mask)); cmp(256'(dat_pd)); cmp(256'(dat_data));

    // Partial data mask: only low bytes update; stripe_end passes through
    dat(PD_END, 8'h0F, 64'hEEEEEEEEEEEEEEEE);
    push("pmask_dat_data", 256'(64'h11223344EEEEEEEE));
    push("pmask_dat_pd", 256'(PD_END));
    tick();
    cmp(256'(dat_data)); cmp(256'(dat_pd));

    // Cell1 full load then partial reload
    idle(); wt(1, 8'hFF, 64'hAAAAAAAAAAAAAAAA); tick();
    idle(); dat(PD_ST, 8'h00, 64'h0); tick();
    idle(); wt(1, 8'h0F, 64'h5555555555555555); tick();
    idle(); dat(PD_ST, 8'h00, 64'h0);
    push("t2_actv_mask1", 256'(8'h0F));
    push("t2_actv_data1", 256'(64'hAAAAAAAA55555555));
    push("t2_reuse_mask0", 256'(8'hFF));
    push("t2_reuse_data0", 256'(64'h0807060504030201));
    tick();
    cmp(256'(wt_actv_mask[15:8])); cmp(256'(wt_actv_data[127:64]));
    cmp(256'(wt_actv_mask[7:0])); cmp(256'(wt_actv_data[63:0]));

    // Cell2: stripe_end alone must not promote; then same-cycle load + promote
    idle(); wt(2, 8'hFF, 64'h1111111111111111); tick();
    idle(); dat(PD_END, 8'hFF, 64'h0);
    push("t3_end_no_promote", 256'(4'b0100));
    tick();
    cmp(256'(wt_shadow_vld));
    idle(); wt(2, 8'hFF, 64'h2222222222222222); dat(PD_ST, 8'hFF, 64'h0);
    push("t3_actv_old", 256'(64'h1111111111111111));
    push("t3_vld_kept", 256'(4'b0100));
    push("t3_no_ovr", 256'(1'b0));
    tick();
    cmp(256'(wt_actv_data[191:128])); cmp(256'(wt_shadow_vld)); cmp(256'(wt_ovr));
    idle(); dat(PD_ST, 8'hFF, 64'h0);
    push("t3_actv_new", 256'(64'h2222222222222222));
    tick();
    cmp(256'(wt_actv_data[191:128]));

    // Zero-sel weight beat is dropped
    idle(); in_wt_pvld = 1'b1; in_wt_mask = 8'hFF; in_wt_data = 64'hDEAD;
    push("zsel_shadow_vld", 256'(4'b0000));
    tick();
    cmp(256'(wt_shadow_vld));

    // Cell3 overwrite: one-cycle ovr, last write wins
    idle(); wt(3, 8'hFF, 64'h3333333333333333);
    push("t4_ovr_first", 256'(1'b0));
    tick();
    cmp(256'(wt_ovr));
    idle(); wt(3, 8'hFF, 64'h4444444444444444);
    push("t4_ovr_pulse", 256'(1'b1));
    tick();
    cmp(256'(wt_ovr));
    idle();
    push("t4_ovr_drop", 256'(1'b0));
    tick();
    cmp(256'(wt_ovr));
    dat(PD_ST, 8'hFF, 64'h0);
    push("t4_actv_data3", 256'(64'h4444444444444444));
    tick();
    cmp(256'(wt_actv_data[255:192]));

    // Reset mid-flight clears state asynchronously and blocks promotion
    idle(); wt(0, 8'hFF, 64'h9999999999999999); tick();
    idle();
    rstn = 1'b0;
    #1;
    push("t5_async_vld", 256'(4'b0000));
    push("t5_async_mask", 256'(32'h0));
    cmp(256'(wt_shadow_vld)); cmp(256'(wt_actv_mask));
    #2 rstn = 1'b1;
    tick();
    dat(PD_ST, 8'hFF, 64'h0);
    push("t5_post_mask", 256'(32'h0));
    push("t5_post_vld", 256'(4'b0000));
    tick();
    cmp(256'(wt_actv_mask)); cmp(256'(wt_shadow_vld));
    idle(); tick();

    if (val_q.size() != 0) begin
      n_bad++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", val_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
